// File: rtl/fruit_spawn_if.sv
// Spawn request channel between the fruit spawn scheduler (master) and the
// fruit object manager (slave). The bomb flag exists only when SPAWN_BOMB_EN
// is defined.
interface fruit_spawn_if;
  logic       spawn_valid;
  logic       spawn_ready;
  logic [4:0] spawn_lane;
  logic [1:0] spawn_type;
`ifdef SPAWN_BOMB_EN
  logic       spawn_bomb;
`endif

  modport master (
    input  spawn_ready,
    output spawn_valid,
    output spawn_lane,
    output spawn_type
`ifdef SPAWN_BOMB_EN
    , output spawn_bomb
`endif
  );

  modport slave (
    output spawn_ready,
    input  spawn_valid,
    input  spawn_lane,
    input  spawn_type
`ifdef SPAWN_BOMB_EN
    , input  spawn_bomb
`endif
  );
endinterface

// File: rtl/fruit_spawn_scheduler.sv
// Fruit spawn scheduler: consumes the 5-bit random stream and turns it into
// frame-paced spawn requests (lane, fruit type) offered over valid/ready.
// Optional feature macro: SPAWN_BOMB_EN adds the spawn_bomb flag, drawn
// together with the fruit type.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | game stopped, nothing pending
// WAIT_GAP  | counting frame ticks down before the next spawn
// DRAW_LANE | drawing a lane; out-of-range words are rejected, with fallback
// DRAW_TYPE | drawing the fruit type (and bomb flag)
// OFFER     | request presented, waiting for the object manager to accept
module fruit_spawn_scheduler #(
  parameter int MIN_GAP   = 8,
  parameter int NUM_LANES = 20,
  parameter int REJ_LIMIT = 7
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [4:0]       rand_data,
  input  logic             enable,
  input  logic             frame_tick,
  fruit_spawn_if.master    spawn,
  output logic [7:0]       spawn_count,
  output logic             busy
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_GAP  = 3'd1,
    S_DRAW_LANE = 3'd2,
    S_DRAW_TYPE = 3'd3,
    S_OFFER     = 3'd4
  } state_t;

  state_t     state, state_next;
  logic [5:0] gap_cnt;
  logic [2:0] rej_cnt;
  logic [4:0] lane_q;
  logic [1:0] type_q;
  logic       valid_c;
  logic       busy_c;

  logic [5:0] gap_load;
  logic       gap_expire;
  logic       lane_ok;
  logic       rej_done;
  logic       accept;

  // Gap reload value: MIN_GAP plus up to 15 extra frames, fits in 6 bits.
  assign gap_load = 6'(MIN_GAP) + {2'b00, rand_data[3:0]};

  // The tick that takes the counter from 1 to 0 also ends the wait, so the
  // request appears exactly two clocks (DRAW_LANE, DRAW_TYPE) after the last
  // counted tick. A counter already at zero leaves on the next clock.
  assign gap_expire = (gap_cnt == 6'd0) || (frame_tick && (gap_cnt == 6'd1));
  assign lane_ok    = ({1'b0, rand_data} < 6'(NUM_LANES));
  assign rej_done   = (rej_cnt == 3'(REJ_LIMIT));
  assign accept     = (state == S_OFFER) && spawn.spawn_ready;

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state decode; a request already offered is never withdrawn.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (enable) state_next = S_WAIT_GAP;
      end
      S_WAIT_GAP: begin
        if (!enable)         state_next = S_IDLE;
        else if (gap_expire) state_next = S_DRAW_LANE;
      end
      S_DRAW_LANE: begin
        if (!enable)                 state_next = S_IDLE;
        else if (lane_ok || rej_done) state_next = S_DRAW_TYPE;
      end
      S_DRAW_TYPE: begin
        if (!enable) state_next = S_IDLE;
        else         state_next = S_OFFER;
      end
      S_OFFER: begin
        if (spawn.spawn_ready) state_next = enable ? S_WAIT_GAP : S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    valid_c = 1'b0;
    busy_c  = 1'b1;
    case (state)
      S_IDLE:  busy_c  = 1'b0;
      S_OFFER: valid_c = 1'b1;
      default: ;
    endcase
  end

  // Gap counter: loaded on start and after each accepted spawn, counts ticks.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      gap_cnt <= 6'd0;
    end else if ((state == S_IDLE) && enable) begin
      gap_cnt <= gap_load;
    end else if (accept) begin
      gap_cnt <= gap_load;
    end else if ((state == S_WAIT_GAP) && enable && frame_tick && (gap_cnt != 6'd0)) begin
      gap_cnt <= gap_cnt - 6'd1;
    end
  end

  // Reject counter: only meaningful inside DRAW_LANE, cleared everywhere else.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rej_cnt <= 3'd0;
    end else if ((state == S_DRAW_LANE) && enable && !lane_ok && !rej_done) begin
      rej_cnt <= rej_cnt + 3'd1;
    end else begin
      rej_cnt <= 3'd0;
    end
  end

  // Lane capture; after REJ_LIMIT rejects the word is folded back into range.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lane_q <= 5'd0;
    end else if ((state == S_DRAW_LANE) && enable) begin
      if (lane_ok)       lane_q <= rand_data;
      else if (rej_done) lane_q <= rand_data - 5'(NUM_LANES);
    end
  end

  // Fruit type capture; held through OFFER.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      type_q <= 2'd0;
    end else if ((state == S_DRAW_TYPE) && enable) begin
      type_q <= rand_data[1:0];
    end
  end

`ifdef SPAWN_BOMB_EN
  logic bomb_q;

  // Bomb flag drawn alongside the type from the upper random bits.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bomb_q <= 1'b0;
    end else if ((state == S_DRAW_TYPE) && enable) begin
      bomb_q <= (rand_data[4:2] == 3'b111);
    end
  end

  assign spawn.spawn_bomb = bomb_q;
`endif

  // Accepted-spawn counter, wraps naturally at 8 bits.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)       spawn_count <= 8'd0;
    else if (accept) spawn_count <= spawn_count + 8'd1;
  end

  assign spawn.spawn_valid = valid_c;
  assign spawn.spawn_lane  = lane_q;
  assign spawn.spawn_type  = type_q;
  assign busy              = busy_c;

endmodule
